// File: rtl/jarvis_pkg.sv
// Shared fetch-stage types: FSM encoding, datapath width, NOP encoding and PC step.
package jarvis_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response port: one request in flight, req/ready accept, rvalid return.
interface fetch_ctrl_if;
  import jarvis_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding slot for a response that arrives while decode is stalled.
// Write wins over read; clear wins over both.
module fetch_skid_buf
  import jarvis_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      full <= 1'b0;
    end else if (wr) begin
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
    if (wr) begin
      instr <= wr_instr;
      pc    <= wr_pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one imem request in flight, redirect flush, skid-buffered decode hand-off.
// Define FETCH_CTRL_PERF_EN to add saturating perf_fetched/perf_redirects counters.
module fetch_ctrl
  import jarvis_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR    = INSTR_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src_exec,
  input  logic [XLEN-1:0] pc_target_exec,
  input  logic            stall_decode,
  fetch_ctrl_if.master    imem,
  output logic [XLEN-1:0] instr_decode,
  output logic [XLEN-1:0] pc_decode,
  output logic [XLEN-1:0] next_pc_decode,
  output logic            valid_decode
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic            skid_full;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            take;
  logic            rsp;
  logic            load_rsp;
  logic            load_skid;
  logic            skid_wr;

  // A full skid in WAIT means the response already landed and no request is in flight.
  assign take      = !valid_decode || !stall_decode;
  assign rsp       = (state == WAIT) && !skid_full && imem.imem_rvalid;
  assign load_skid = skid_full && !stall_decode && !pc_src_exec;
  assign load_rsp  = rsp && take && !pc_src_exec;
  assign skid_wr   = rsp && !take && !pc_src_exec;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr       (skid_wr),
    .rd       (load_skid),
    .clr      (pc_src_exec),
    .wr_instr (imem.imem_rdata),
    .wr_pc    (fetch_pc),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_VECTOR;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_VECTOR;
      instr_decode   <= NOP_INSTR;
      pc_decode      <= '0;
      next_pc_decode <= '0;
      valid_decode   <= 1'b0;
    end else begin
      if (pc_src_exec) begin
        valid_decode <= 1'b0;
        instr_decode <= NOP_INSTR;
      end else if (load_skid) begin
        valid_decode   <= 1'b1;
        instr_decode   <= skid_instr;
        pc_decode      <= skid_pc;
        next_pc_decode <= pc_next(skid_pc);
      end else if (load_rsp) begin
        valid_decode   <= 1'b1;
        instr_decode   <= imem.imem_rdata;
        pc_decode      <= fetch_pc;
        next_pc_decode <= pc_next(fetch_pc);
      end else if (!stall_decode) begin
        valid_decode <= 1'b0;
        instr_decode <= NOP_INSTR;
      end

      if (pc_src_exec) begin
        fetch_pc <= pc_target_exec;
      end else if (rsp) begin
        fetch_pc <= pc_next(fetch_pc);
      end

      case (state)
        IDLE: begin
          state          <= REQ;
          imem.imem_req  <= 1'b1;
          imem.imem_addr <= pc_src_exec ? pc_target_exec : fetch_pc;
        end
        REQ: begin
          if (imem.imem_ready) begin
            imem.imem_req <= 1'b0;
            state         <= pc_src_exec ? DRAIN : WAIT;
          end else if (pc_src_exec) begin
            imem.imem_addr <= pc_target_exec;
          end
        end
        WAIT: begin
          if (pc_src_exec) begin
            // Nothing left in flight once the response is here or parked: refetch at once.
            if (skid_full || imem.imem_rvalid) begin
              state          <= REQ;
              imem.imem_req  <= 1'b1;
              imem.imem_addr <= pc_target_exec;
            end else begin
              state <= DRAIN;
            end
          end else if (skid_full) begin
            if (!stall_decode) begin
              state          <= REQ;
              imem.imem_req  <= 1'b1;
              imem.imem_addr <= fetch_pc;
            end
          end else if (imem.imem_rvalid && take) begin
            state          <= REQ;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc_next(fetch_pc);
          end
        end
        DRAIN: begin
          if (imem.imem_rvalid) begin
            state          <= REQ;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc_src_exec ? pc_target_exec : fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if ((load_skid || load_rsp) && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (pc_src_exec && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench: program-order PC queue model plus a random-latency memory responder.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src_exec;
  logic [31:0] pc_target_exec;
  logic        stall_decode;
  logic [31:0] instr_decode;
  logic [31:0] pc_decode;
  logic [31:0] next_pc_decode;
  logic        valid_decode;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  fetch_ctrl_if imem_bus ();

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc_src_exec    (pc_src_exec),
    .pc_target_exec (pc_target_exec),
    .stall_decode   (stall_decode),
    .imem           (imem_bus),
    .instr_decode   (instr_decode),
    .pc_decode      (pc_decode),
    .next_pc_decode (next_pc_decode),
`ifdef FETCH_CTRL_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects),
`endif
    .valid_decode   (valid_decode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
  endfunction

  // Reference: the PCs decode must consume, in order, since the last reset/redirect.
  logic [31:0] exp_q[$];
  logic [31:0] next_push;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    next_push = start;
    refill();
  endtask

  // Stimulus controls and memory responder state.
  logic        rst_nx, stall_nx, redir_nx;
  logic [31:0] tgt_nx;
  int          rdy_pct, lat_min, lat_max;
  logic        out_vld;
  int          out_cnt;
  logic [31:0] out_addr;
  logic        hold_chk;
  logic [31:0] hold_addr;
  int          redir_cnt;
  int          load_cnt;

  task automatic step();
    @(negedge clk);
    rst            = rst_nx;
    stall_decode   = stall_nx;
    pc_src_exec    = redir_nx;
    pc_target_exec = redir_nx ? tgt_nx : $urandom();
    imem_bus.imem_ready  = ($urandom_range(99) < rdy_pct);
    imem_bus.imem_rvalid = out_vld && (out_cnt == 0);
    imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_word(out_addr) : $urandom();
    #4;
    if (rst) begin
      out_vld   = 1'b0;
      hold_chk  = 1'b0;
      redir_cnt = 0;
      model_restart(32'h0);
    end else begin
      if (hold_chk) begin
        check("req_held", imem_bus.imem_req, 1'b1);
        check("addr_held", imem_bus.imem_addr, hold_addr);
      end
      hold_chk  = imem_bus.imem_req && !imem_bus.imem_ready;
      hold_addr = pc_src_exec ? pc_target_exec : imem_bus.imem_addr;
      if (imem_bus.imem_rvalid) out_vld = 1'b0;
      else if (out_vld && out_cnt > 0) out_cnt--;
      if (imem_bus.imem_req && imem_bus.imem_ready) begin
        check("single_outstanding", out_vld, 1'b0);
        out_vld  = 1'b1;
        out_cnt  = $urandom_range(lat_max, lat_min);
        out_addr = imem_bus.imem_addr;
      end
      if (pc_src_exec) begin
        redir_cnt++;
        model_restart(pc_target_exec);
      end
    end
  endtask

  // Monitor: every consumed instruction pops the next expected PC.
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  always begin
    logic [31:0] pc_e;
    @(negedge clk);
    #3;
    if (rst) begin
      load_cnt   = 0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (valid_decode && (!prev_valid || !prev_stall)) load_cnt++;
      if (valid_decode && !stall_decode) begin
        if (exp_q.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          pc_e = exp_q.pop_front();
          refill();
          check("pc_decode", pc_decode, pc_e);
          check("instr_decode", instr_decode, mem_word(pc_e));
          check("next_pc_decode", next_pc_decode, pc_e + 32'd4);
        end
      end else if (!valid_decode) begin
        check("nop_when_invalid", instr_decode, NOP);
      end
      prev_valid = valid_decode;
      prev_stall = stall_decode;
    end
  end

  initial begin
    logic [31:0] held;
    rst = 1'b1; stall_decode = 1'b0; pc_src_exec = 1'b0; pc_target_exec = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    rst_nx = 1'b1; stall_nx = 1'b0; redir_nx = 1'b0; tgt_nx = '0;
    rdy_pct = 100; lat_min = 0; lat_max = 0;
    out_vld = 1'b0; out_cnt = 0; out_addr = '0; hold_chk = 1'b0; hold_addr = '0;
    redir_cnt = 0; load_cnt = 0;
    model_restart(32'h0);

    repeat (3) step();
    check("rst_req", imem_bus.imem_req, 1'b0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    check("rst_instr", instr_decode, NOP);
    check("rst_pc", pc_decode, 32'h0);
    check("rst_next_pc", next_pc_decode, 32'h0);
    check("rst_valid", valid_decode, 1'b0);

    // Cycle-exact startup with an always-ready, next-cycle memory.
    rst_nx = 1'b0;
    step();
    check("c0_idle_req", imem_bus.imem_req, 1'b0);
    step();
    check("c1_req", imem_bus.imem_req, 1'b1);
    check("c1_addr", imem_bus.imem_addr, 32'h0);
    step();
    step();
    check("c3_valid", valid_decode, 1'b1);
    check("c3_pc", pc_decode, 32'h0);
    check("c3_next_pc", next_pc_decode, 32'h4);
    check("c3_instr", instr_decode, 32'h0010_0093);
    check("c3_next_addr", imem_bus.imem_addr, 32'h4);
    step();
    step();
    check("c5_valid", valid_decode, 1'b1);
    check("c5_pc", pc_decode, 32'h4);

    // Decode stall: response parks in the skid, fetch pauses, order preserved on release.
    stall_nx = 1'b1;
    repeat (4) step();
    held = pc_decode;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_req", imem_bus.imem_req, 1'b0);
      check("stall_valid", valid_decode, 1'b1);
      check("stall_pc_hold", pc_decode, held);
    end
    stall_nx = 1'b0;
    step();
    step();
    check("release_valid", valid_decode, 1'b1);
    check("release_pc", pc_decode, held + 32'd4);
    check("release_req_addr", imem_bus.imem_addr, held + 32'd8);

    // Redirect while the response is still outstanding.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !(out_vld && out_cnt == 3); i++) step();
    if (!(out_vld && out_cnt == 3)) fail_now("wait_accept");
    redir_nx = 1'b1; tgt_nx = 32'h0000_0100;
    step();
    redir_nx = 1'b0;
    step();
    check("drain_valid", valid_decode, 1'b0);
    check("drain_no_req", imem_bus.imem_req, 1'b0);
    for (int i = 0; i < 20 && !imem_bus.imem_req; i++) step();
    if (!imem_bus.imem_req) fail_now("wait_req_after_drain");
    else check("drain_next_addr", imem_bus.imem_addr, 32'h0000_0100);

    // Redirect coinciding with rvalid.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 40 && !(out_vld && out_cnt == 0); i++) step();
    if (!(out_vld && out_cnt == 0)) fail_now("wait_rvalid_next");
    redir_nx = 1'b1; tgt_nx = 32'h0000_0200;
    step();
    redir_nx = 1'b0;
    step();
    check("same_req", imem_bus.imem_req, 1'b1);
    check("same_addr", imem_bus.imem_addr, 32'h0000_0200);
    check("same_valid", valid_decode, 1'b0);

    // PC wrap at the top of the address space.
    lat_min = 0; lat_max = 0;
    redir_nx = 1'b1; tgt_nx = 32'hFFFF_FFFC;
    step();
    redir_nx = 1'b0;
    for (int i = 0; i < 30 && !(valid_decode && pc_decode == 32'hFFFF_FFFC); i++) step();
    if (!(valid_decode && pc_decode == 32'hFFFF_FFFC)) fail_now("wait_wrap_pc");
    else check("wrap_next_pc", next_pc_decode, 32'h0);
    for (int i = 0; i < 20 && !imem_bus.imem_req; i++) step();
    if (!imem_bus.imem_req) fail_now("wait_wrap_req");
    else check("wrap_addr", imem_bus.imem_addr, 32'h0);

`ifdef FETCH_CTRL_PERF_EN
    rst_nx = 1'b1;
    repeat (2) step();
    check("perf_fetched_rst", perf_fetched, 32'h0);
    check("perf_redirects_rst", perf_redirects, 32'h0);
    rst_nx = 1'b0;
    for (int i = 0; i < 200 && load_cnt < 10; i++) begin
      redir_nx = (i == 6 || i == 13);
      tgt_nx   = 32'h40 * (i + 1);
      step();
    end
    redir_nx = 1'b0;
    if (load_cnt < 10) fail_now("wait_ten_loads");
    check("perf_fetched_10", perf_fetched, load_cnt);
    check("perf_redirects_2", perf_redirects, redir_cnt);
`endif

    // Random traffic with a mid-run reset.
    rdy_pct = 70; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      stall_nx = ($urandom_range(99) < 30);
      redir_nx = ($urandom_range(99) < 3);
      tgt_nx   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt_nx = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
      rst_nx   = (i >= 700 && i < 702);
      step();
`ifdef FETCH_CTRL_PERF_EN
      if (i == 701) begin
        check("perf_fetched_midrst", perf_fetched, 32'h0);
        check("perf_redirects_midrst", perf_redirects, 32'h0);
      end
`endif
    end
    stall_nx = 1'b0; redir_nx = 1'b0; rst_nx = 1'b0;
    repeat (10) step();
`ifdef FETCH_CTRL_PERF_EN
    check("perf_fetched_end", perf_fetched, load_cnt);
    check("perf_redirects_end", perf_redirects, redir_cnt);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
